ctrl_decode_stage: RTL and testbench
====================================

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 Parameters SHALL be: EN_MEXT, default 0, enables RV32M decode; TAG_W, default 4, sideband tag width; CNT_W, default 8, illegal-counter width.
REQ-003 Inputs SHALL be: in_valid in 1, instruction present; in_instr in 32, instruction word; in_tag in TAG_W, sideband tag; in_ready out 1, stage accepts input.
REQ-004 Output handshake ports SHALL be: out_valid out 1, decoded entry present; out_ready in 1, consumer accepts entry.
REQ-005 Output control ports SHALL be: out_regwrite 1, out_alusrc 1, out_memwrite 1, out_resultsrc 2, out_branch 1, out_jump 1, out_immsrc 3.
REQ-006 Remaining outputs SHALL be: out_aluctrl out 5, ALU operation; out_illegal out 1, illegal instruction; out_tag out TAG_W, copied tag.
REQ-007 Control inputs SHALL be: flush in 1, discard all entries; cnt_clr in 1, clear the counter. Status output: illegal_cnt out CNT_W, saturating illegal count.

Function
REQ-008 out_aluctrl encoding SHALL be: add 00000, sub 00001, and 00010, or 00011, xor 00100, slt 00101, sll 00110, srl 00111, sra 01000, sltu 01001, passb 01010, and M-ops {2'b10, funct3}.
REQ-009 Decode by opcode SHALL be:
- lw: add, regwrite=1, alusrc=1, resultsrc=01, immsrc=000.
- sw: add, alusrc=1, memwrite=1, immsrc=001.
- R-type: regwrite=1.
- I-ALU: regwrite=1, alusrc=1.
- branch: branch=1, immsrc=010.
- jal: jump=1, regwrite=1, resultsrc=10, immsrc=011.
- jalr: add, jump=1, regwrite=1, alusrc=1, resultsrc=10.
- lui: passb, regwrite=1, alusrc=1, immsrc=100.
- auipc: add, regwrite=1, alusrc=1, immsrc=100.
REQ-010 R-type and I-ALU ALU ops SHALL decode from funct3 as add, sll, slt, sltu, xor, srl, or, and. R-type funct3 000 with funct7 0100000 SHALL give sub; funct3 101 with funct7 0100000 SHALL give sra in both formats; I-type funct3 000 SHALL always give add.
REQ-011 Branch ALU ops SHALL be: funct3 000/001 sub; 100/101 slt; 110/111 sltu; 010/011 illegal.
REQ-012 When EN_MEXT=1, R-type with funct7 0000001 SHALL give {2'b10, funct3}. When EN_MEXT=0 the same encoding SHALL be illegal.
REQ-013 An instruction SHALL be illegal on any of:
- instr[1:0] != 11;
- unlisted opcode;
- R-type funct7 outside the allowed set;
- I-type shift with imm[11:5] not 0000000/0100000, or 0100000 with sll.
An illegal entry SHALL output out_illegal=1, all write/branch/jump controls 0, and aluctrl 00000.
REQ-014 Latency SHALL be one cycle: an input accepted at edge N is visible on the outputs after edge N when the output is empty or draining.
REQ-015 Storage SHALL be a 2-entry skid buffer. in_ready SHALL be registered and equal to 0 only when both entries are occupied. Entries SHALL leave in acceptance order.
REQ-016 An entry SHALL be held stable while out_valid=1 and out_ready=0. A transfer SHALL occur only when out_valid and out_ready are both 1.
REQ-017 A simultaneous accept and drain SHALL keep occupancy unchanged, with no bubble and no loss.
REQ-018 flush SHALL be synchronous: both entries are cleared, an input accepted in the same cycle is dropped, and next cycle out_valid=0 and in_ready=1. flush SHALL have priority over all handshakes.
REQ-019 illegal_cnt SHALL increment by 1 for each accepted illegal input that is not flushed in the same cycle, and SHALL saturate at all-ones.
REQ-020 cnt_clr SHALL zero illegal_cnt and SHALL take priority over a same-cycle increment.

Reset
REQ-021 While rst_n=0, and asynchronously: out_valid=0, in_ready=1, both entries invalid, all data outputs 0, and illegal_cnt=0.
REQ-022 Reset asserted mid-operation SHALL discard all entries. The first accept SHALL be possible at the first rising edge after rst_n is released.

Verification
REQ-023 Accept R-type sub (funct7 0100000, funct3 000) with out_ready=1 -> next cycle out_valid=1, aluctrl 00001, regwrite=1, illegal=0.
REQ-024 Hold out_ready=0 and offer 3 back-to-back lw/sw/beq -> in_ready=0 after 2 accepts; outputs stay on lw; release -> lw, sw, beq in order.
REQ-025 EN_MEXT=0 vs 1, input 0x02B50533 (mul) -> illegal=1 with illegal_cnt=1, vs aluctrl 10000 with illegal=0.
REQ-026 Both entries full and flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input is not delivered.
REQ-027 CNT_W=2, 5 illegal words (0x00000000) -> illegal_cnt sticks at 3; cnt_clr=1 together with a 6th illegal word -> illegal_cnt=0.
REQ-028 Assert rst_n=0 asynchronously while 2 entries are held -> out_valid=0, in_ready=1 immediately and illegal_cnt=0.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
`timescale 1ns/1ps
// RV32I(+M) control decode behind a 2-entry skid buffer; one cycle of latency.
// in_ready is registered and drops only when both entries are held; flush clears everything.
module ctrl_decode_stage #(
  parameter bit EN_MEXT = 1'b0,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_regwrite,
  output logic             out_alusrc,
  output logic             out_memwrite,
  output logic [1:0]       out_resultsrc,
  output logic             out_branch,
  output logic             out_jump,
  output logic [2:0]       out_immsrc,
  output logic [4:0]       out_aluctrl,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int EW = 16 + TAG_W;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_AND = 5'b00010, A_OR = 5'b00011,
                         A_XOR = 5'b00100, A_SLT = 5'b00101, A_SLL = 5'b00110, A_SRL = 5'b00111,
                         A_SRA = 5'b01000, A_SLTU = 5'b01001, A_PASSB = 5'b01010;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       rw, as, mw, br, jp, ill;
  logic [1:0] rs;
  logic [2:0] im;
  logic [4:0] alu, base_alu;
  logic [15:0] dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    case (f3)
      3'b000:  base_alu = A_ADD;
      3'b001:  base_alu = A_SLL;
      3'b010:  base_alu = A_SLT;
      3'b011:  base_alu = A_SLTU;
      3'b100:  base_alu = A_XOR;
      3'b101:  base_alu = A_SRL;
      3'b110:  base_alu = A_OR;
      default: base_alu = A_AND;
    endcase
  end

  always_comb begin
    rw = 1'b0; as = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; ill = 1'b0;
    rs = 2'b00; im = 3'b000; alu = A_ADD;
    case (opcode)
      OP_LW:    begin rw = 1'b1; as = 1'b1; rs = 2'b01; end
      OP_SW:    begin as = 1'b1; mw = 1'b1; im = 3'b001; end
      OP_R: begin
        rw = 1'b1;
        if (f7 == 7'b0000000)                     alu = base_alu;
        else if (f7 == 7'b0100000 && f3 == 3'b000) alu = A_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) alu = A_SRA;
        else if (f7 == 7'b0000001 && EN_MEXT)      alu = {2'b10, f3};
        else                                       ill = 1'b1;
      end
      OP_I: begin
        rw  = 1'b1;
        as  = 1'b1;
        alu = base_alu;
        // Shift immediates carry a funct7-like field in imm[11:5]
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      alu = A_SRA;
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OP_BR: begin
        br = 1'b1;
        im = 3'b010;
        case (f3)
          3'b000, 3'b001: alu = A_SUB;
          3'b100, 3'b101: alu = A_SLT;
          3'b110, 3'b111: alu = A_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      OP_JAL:   begin jp = 1'b1; rw = 1'b1; rs = 2'b10; im = 3'b011; end
      OP_JALR:  begin jp = 1'b1; rw = 1'b1; as = 1'b1; rs = 2'b10; end
      OP_LUI:   begin alu = A_PASSB; rw = 1'b1; as = 1'b1; im = 3'b100; end
      OP_AUIPC: begin rw = 1'b1; as = 1'b1; im = 3'b100; end
      default:  ill = 1'b1;
    endcase
    if (ill) dec = 16'h0001;
    else     dec = {rw, as, mw, rs, br, jp, im, alu, 1'b0};
  end

  logic [EW-1:0]    head_q, head_d, skid_q, skid_d;
  logic             head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = head_vld_q && out_ready;

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!head_vld_q) begin
      if (accept) begin
        head_d     = {dec, in_tag};
        head_vld_d = 1'b1;
      end
    end else if (!skid_vld_q) begin
      if (drain && accept) begin
        head_d = {dec, in_tag};
      end else if (drain) begin
        head_vld_d = 1'b0;
      end else if (accept) begin
        skid_d     = {dec, in_tag};
        skid_vld_d = 1'b1;
      end
    end else if (drain) begin
      head_d     = skid_q;
      skid_vld_d = 1'b0;
    end
    in_ready_d = !(head_vld_d && skid_vld_d);

    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (accept && ill && !flush && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = head_vld_q;
  assign illegal_cnt = cnt_q;
  assign {out_regwrite, out_alusrc, out_memwrite, out_resultsrc, out_branch, out_jump,
          out_immsrc, out_aluctrl, out_illegal, out_tag} = head_vld_q ? head_q : '0;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
`timescale 1ns/1ps
// Two instances (RV32I/8-bit counter and RV32IM/2-bit counter) share one stimulus stream
// and are compared against a queue-based reference model every cycle.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush, cnt_clr;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;

  logic       r0, v0, rw0, as0, mw0, br0, jp0, il0;
  logic [1:0] rs0;
  logic [2:0] im0;
  logic [4:0] al0;
  logic [3:0] tg0;
  logic [7:0] cnt0;
  logic       r1, v1, rw1, as1, mw1, br1, jp1, il1;
  logic [1:0] rs1;
  logic [2:0] im1;
  logic [4:0] al1;
  logic [3:0] tg1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.EN_MEXT(1'b0), .TAG_W(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_tag(in_tag),
    .in_ready(r0), .out_valid(v0), .out_ready(out_ready), .out_regwrite(rw0),
    .out_alusrc(as0), .out_memwrite(mw0), .out_resultsrc(rs0), .out_branch(br0),
    .out_jump(jp0), .out_immsrc(im0), .out_aluctrl(al0), .out_illegal(il0), .out_tag(tg0),
    .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt0));

  ctrl_decode_stage #(.EN_MEXT(1'b1), .TAG_W(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_tag(in_tag),
    .in_ready(r1), .out_valid(v1), .out_ready(out_ready), .out_regwrite(rw1),
    .out_alusrc(as1), .out_memwrite(mw1), .out_resultsrc(rs1), .out_branch(br1),
    .out_jump(jp1), .out_immsrc(im1), .out_aluctrl(al1), .out_illegal(il1), .out_tag(tg1),
    .flush(flush), .cnt_clr(cnt_clr), .illegal_cnt(cnt1));

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4, SLT = 5'd5,
                         SLL = 5'd6, SRL = 5'd7, SRA = 5'd8, SLTU = 5'd9, PASSB = 5'd10;
  localparam logic [4:0] F3OP [8] = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
  localparam logic [4:0] BROP [8] = '{SUB, SUB, ADD, ADD, SLT, SLT, SLTU, SLTU};
  localparam logic [6:0] OPS  [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] mq[$];
  int mcnt0, mcnt1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {regwrite, alusrc, memwrite, resultsrc, branch, jump, immsrc, aluctrl, illegal}
  function automatic logic [15:0] ref_dec(input logic [31:0] w, input bit mext);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic rw, as, mw, br, jp, ill, is_shift;
    logic [1:0] rs;
    logic [2:0] im;
    logic [4:0] al;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    rw = 0; as = 0; mw = 0; br = 0; jp = 0; ill = 0; rs = 0; im = 0; al = ADD;
    is_shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (op == 7'h03) begin rw = 1; as = 1; rs = 2'b01; end
    else if (op == 7'h23) begin as = 1; mw = 1; im = 3'b001; end
    else if (op == 7'h33) begin
      rw  = 1;
      ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (mext && f7 == 7'h01));
      al  = (f7 == 7'h01) ? {2'b10, f3} : (f7 == 7'h20) ? ((f3 == 3'd0) ? SUB : SRA) : F3OP[f3];
    end
    else if (op == 7'h13) begin
      rw = 1; as = 1;
      ill = is_shift && !((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5));
      al  = (f3 == 3'd5 && f7 == 7'h20) ? SRA : F3OP[f3];
    end
    else if (op == 7'h63) begin br = 1; im = 3'b010; ill = (f3 == 3'd2 || f3 == 3'd3); al = BROP[f3]; end
    else if (op == 7'h6f) begin jp = 1; rw = 1; rs = 2'b10; im = 3'b011; end
    else if (op == 7'h67) begin jp = 1; rw = 1; as = 1; rs = 2'b10; end
    else if (op == 7'h37) begin al = PASSB; rw = 1; as = 1; im = 3'b100; end
    else if (op == 7'h17) begin rw = 1; as = 1; im = 3'b100; end
    else ill = 1;
    if (ill) return 16'h0001;
    return {rw, as, mw, rs, br, jp, im, al, 1'b0};
  endfunction

  task automatic check_outputs();
    chk("in_ready0", r0, mq.size() < 2);
    chk("in_ready1", r1, mq.size() < 2);
    chk("out_valid0", v0, mq.size() > 0);
    chk("out_valid1", v1, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("ctrl0", {rw0, as0, mw0, rs0, br0, jp0, im0, al0, il0}, ref_dec(mq[0][31:0], 1'b0));
      chk("ctrl1", {rw1, as1, mw1, rs1, br1, jp1, im1, al1, il1}, ref_dec(mq[0][31:0], 1'b1));
      chk("tag0", tg0, mq[0][35:32]);
      chk("tag1", tg1, mq[0][35:32]);
    end else begin
      chk("idle0", {rw0, as0, mw0, rs0, br0, jp0, im0, al0, il0, tg0}, 0);
      chk("idle1", {rw1, as1, mw1, rs1, br1, jp1, im1, al1, il1, tg1}, 0);
    end
    chk("cnt0", cnt0, mcnt0);
    chk("cnt1", cnt1, mcnt1);
  endtask

  // Drive one cycle of inputs at a falling edge, advance the model, check at the next falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [3:0] tg,
                      input logic ordy, input logic fl, input logic clr);
    bit acc, drn;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy; flush = fl; cnt_clr = clr;
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    if (clr) begin
      mcnt0 = 0; mcnt1 = 0;
    end else if (acc && !fl) begin
      if (ref_dec(ins, 1'b0) == 16'h0001 && mcnt0 < 255) mcnt0++;
      if (ref_dec(ins, 1'b1) == 16'h0001 && mcnt1 < 3)   mcnt1++;
    end
    if (fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({tg, ins});
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned pick;
    w = $urandom;
    pick = $urandom_range(0, 11);
    if (pick < 9) w[6:0] = OPS[pick];
    else if (pick == 9) w[6:2] = OPS[$urandom_range(0, 8)][6:2];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] i_sub, i_lw, i_sw, i_beq;

  initial begin
    i_sub = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    i_lw  = {12'd4, 5'd1, 3'b010, 5'd5, 7'b0000011};
    i_sw  = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
    i_beq = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
    rst_n = 1'b0; in_valid = 0; in_instr = 0; in_tag = 0; out_ready = 0; flush = 0; cnt_clr = 0;
    mcnt0 = 0; mcnt1 = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    step(1, i_sub, 4'h1, 1, 0, 0);
    chk("sub_valid", v0, 1); chk("sub_alu", al0, 5'b00001);
    chk("sub_rw", rw0, 1);   chk("sub_ill", il0, 0);

    step(0, 0, 0, 1, 0, 0);
    step(1, i_lw, 4'h2, 0, 0, 0);
    step(1, i_sw, 4'h3, 0, 0, 0);
    chk("full_in_ready", r0, 0); chk("hold_lw_rs", rs0, 2'b01);
    step(1, i_beq, 4'h4, 0, 0, 0);
    chk("blocked_in_ready", r0, 0); chk("hold_lw_tag", tg0, 4'h2);
    step(1, i_beq, 4'h4, 1, 0, 0);
    chk("order_sw", mw0, 1);
    step(1, i_beq, 4'h4, 1, 0, 0);
    chk("order_beq_br", br0, 1); chk("order_beq_alu", al0, 5'b00001);

    step(1, 32'h02B50533, 4'h5, 1, 0, 0);
    chk("mul_ill0", il0, 1); chk("mul_cnt0", cnt0, 1);
    chk("mul_ill1", il1, 0); chk("mul_alu1", al1, 5'b10000);

    for (int k = 0; k < 5; k++) step(1, 32'h0, 4'h6, 1, 0, 0);
    chk("sat_cnt1", cnt1, 3); chk("cnt0_six", cnt0, 6);
    step(1, 32'h0, 4'h7, 1, 0, 1);
    chk("clr_cnt1", cnt1, 0); chk("clr_cnt0", cnt0, 0);
    step(0, 0, 0, 1, 0, 0);

    step(1, i_lw, 4'h8, 0, 0, 0);
    step(1, i_sw, 4'h9, 0, 0, 0);
    step(1, i_beq, 4'hA, 0, 1, 0);
    chk("flush_valid", v0, 0); chk("flush_ready", r0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_no_deliver", v0, 0);

    step(1, 32'h0, 4'hB, 0, 0, 0);
    step(1, 32'h0, 4'hC, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", v0, 0); chk("arst_ready", r0, 1);
    chk("arst_cnt0", cnt0, 0); chk("arst_valid1", v1, 0);
    mq.delete(); mcnt0 = 0; mcnt1 = 0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, rand_instr(), 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
